// File: rtl/ic555_pkg.sv
// Shared types and defaults for the 555 comparator/latch/output stage model.
package ic555_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    DISCH  = 2'd2
  } state_t;

  localparam real VCC_DEF       = 5.0;
  localparam real THR_FRAC_DEF  = 2.0 / 3.0;
  localparam real TRIG_FRAC_DEF = 1.0 / 3.0;

  // Comparator threshold as a fraction of the supply.
  function automatic real thr(input real vcc, input real frac);
    return vcc * frac;
  endfunction

endpackage

// File: rtl/ic555_phase_counter.sv
// Saturating phase-length counter with synchronous clear and count enable.
module ic555_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Clear wins over count; stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != CNT_MAX)) begin
      q <= q + CNT_ONE;
    end
  end

endmodule

// File: rtl/ic555_astable_ctrl.sv
// 555 comparator/latch/output stage: samples the timing cap voltage, switches the
// drive between VCC and ground at the 2/3 and 1/3 thresholds, and measures the high
// and low phase lengths of every complete astable cycle.
module ic555_astable_ctrl
  import ic555_pkg::*;
#(
  parameter real VCC       = VCC_DEF,
  parameter real THR_FRAC  = THR_FRAC_DEF,
  parameter real TRIG_FRAC = TRIG_FRAC_DEF,
  parameter int  CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  real              vcap,
  output real              vout,
  output logic             out_q,
  output logic             disch,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic [CNT_W-1:0] cycles
);

  localparam real VTHR  = thr(VCC, THR_FRAC);
  localparam real VTRIG = thr(VCC, TRIG_FRAC);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  state_t           state_next;
  logic             out_q_next;
  logic             disch_next;
  real              vout_next;
  logic             cycle_done;
  logic             h_clr;
  logic             h_en;
  logic             l_clr;
  logic             l_en;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] l_q;
  logic [CNT_W-1:0] l_inc;
  logic             first_done_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: upper threshold is tested first so a cap already above it on entry
  // to CHARGE flips straight to DISCH on the following edge.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (en) state_next = CHARGE;
      CHARGE:  if (!en) state_next = IDLE;
               else if (vcap >= VTHR) state_next = DISCH;
      DISCH:   if (!en) state_next = IDLE;
               else if (vcap <= VTRIG) state_next = CHARGE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so a crossing sampled at an edge drives vout at that edge.
  always_comb begin
    out_q_next = (state_next == CHARGE);
    disch_next = (state_next == DISCH);
    vout_next  = out_q_next ? VCC : 0.0;
    cycle_done = (state_reg == DISCH) && (state_next == CHARGE);
    // Each counter counts edges spent in its phase, including the leaving edge,
    // and restarts on the edge that enters its phase.
    h_en       = (state_reg == CHARGE);
    h_clr      = ((state_next == CHARGE) && (state_reg != CHARGE)) || (state_next == IDLE);
    l_en       = (state_reg == DISCH);
    l_clr      = ((state_next == DISCH) && (state_reg != DISCH)) || (state_next == IDLE);
    // The low count is captured on its leaving edge, so take the value it is about to hold.
    l_inc      = (l_q == CNT_MAX) ? l_q : (l_q + CNT_ONE);
  end

  ic555_phase_counter #(.CNT_W(CNT_W)) u_high_ctr (
    .clk (clk),
    .rst (rst),
    .clr (h_clr),
    .en  (h_en),
    .q   (h_q)
  );

  ic555_phase_counter #(.CNT_W(CNT_W)) u_low_ctr (
    .clk (clk),
    .rst (rst),
    .clr (l_clr),
    .en  (l_en),
    .q   (l_q)
  );

  // Registered outputs and per-cycle measurement capture. The cycle that closes the
  // start-up charge from 0 V is not representative, so it only arms first_done_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q          <= 1'b0;
      disch          <= 1'b0;
      vout           <= 0.0;
      high_cnt       <= '0;
      low_cnt        <= '0;
      meas_valid     <= 1'b0;
      cycles         <= '0;
      first_done_reg <= 1'b0;
    end else begin
      out_q      <= out_q_next;
      disch      <= disch_next;
      vout       <= vout_next;
      meas_valid <= 1'b0;
      if (state_next == IDLE) begin
        first_done_reg <= 1'b0;
      end else if (cycle_done) begin
        if (first_done_reg) begin
          high_cnt   <= h_q;
          low_cnt    <= l_inc;
          meas_valid <= 1'b1;
          if (cycles != CNT_MAX) begin
            cycles <= cycles + CNT_ONE;
          end
        end else begin
          first_done_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ic555_astable_ctrl.sv
// Directed bench for the 555 output stage: vector table for thresholds and a forced
// cycle, hand sequences for saturation / enable drop / async reset, and a closed RC loop.
module tb_ic555_astable_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  real         vcap = 0.0;

  real         vout;
  logic        out_q, disch, meas_valid;
  logic [15:0] high_cnt, low_cnt, cycles;

  real         vout4;
  logic        out_q4, disch4, meas_valid4;
  logic [3:0]  high_cnt4, low_cnt4, cycles4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ic555_astable_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .vcap(vcap), .vout(vout), .out_q(out_q),
    .disch(disch), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .meas_valid(meas_valid), .cycles(cycles)
  );

  ic555_astable_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .vcap(vcap), .vout(vout4), .out_q(out_q4),
    .disch(disch4), .high_cnt(high_cnt4), .low_cnt(low_cnt4),
    .meas_valid(meas_valid4), .cycles(cycles4)
  );

  typedef struct packed {
    logic en;
    int   vmv;     // vcap in millivolts
    logic q;
    logic d;
    logic mv;
    int   hc;
    int   lc;
    int   cy;
  } vec_t;

  vec_t vecs [0:21];
  int   nvec = 0;

  task automatic add(input logic e, input int vmv, input logic q, input logic d,
                     input logic mv, input int hc, input int lc, input int cy);
    vecs[nvec] = '{en: e, vmv: vmv, q: q, d: d, mv: mv, hc: hc, lc: lc, cy: cy};
    nvec++;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %f, expected %f", name, act, exp);
  endtask

  task automatic chk_ok(input string name, input logic ok, input real act, input string req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %f, required %s", name, act, req);
  endtask

  task automatic step(input logic e, input real v);
    en   = e;
    vcap = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    vcap = 0.0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Closed-loop state
  real    vc, vmin, vmax, tau_ratio;
  logic   started;
  int     nmeas, prev_h, prev_l, dh, dl;

  initial begin
    // ---------------- reset state ----------------
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_r("rst_vout", vout, 0.0);
    chk("rst_out_q", out_q, 0);
    chk("rst_disch", disch, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_high_cnt", high_cnt, 0);
    chk("rst_low_cnt", low_cnt, 0);
    chk("rst_cycles", cycles, 0);
    rst = 1'b0;

    // ---------------- vector table: thresholds + forced 10/5 cycle ----------------
    add(1, 0,    1, 0, 0, 0, 0, 0);   // IDLE -> CHARGE regardless of vcap
    add(1, 3330, 1, 0, 0, 0, 0, 0);   // just below 2/3 VCC: hold
    add(1, 3340, 0, 1, 0, 0, 0, 0);   // crosses upper threshold
    add(1, 2000, 0, 1, 0, 0, 0, 0);
    add(1, 1670, 0, 1, 0, 0, 0, 0);   // just above 1/3 VCC: hold
    add(1, 1660, 1, 0, 0, 0, 0, 0);   // closes start-up cycle: no measurement
    for (int i = 0; i < 9; i++) add(1, 2500, 1, 0, 0, 0, 0, 0);
    add(1, 3340, 0, 1, 0, 0, 0, 0);   // 10th CHARGE edge
    for (int i = 0; i < 4; i++) add(1, 2000, 0, 1, 0, 0, 0, 0);
    add(1, 1000, 1, 0, 1, 10, 5, 1);  // 5th DISCH edge: measurement
    add(1, 2500, 1, 0, 0, 10, 5, 1);  // pulse lasts one clock

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].en, real'(vecs[i].vmv) / 1000.0);
      $display("vec %0d: en=%0b vcap=%0dmV -> out_q=%0b disch=%0b vout=%f mv=%0b h=%0d l=%0d cyc=%0d",
               i, vecs[i].en, vecs[i].vmv, out_q, disch, vout, meas_valid,
               high_cnt, low_cnt, cycles);
      chk($sformatf("vec%0d_out_q", i), out_q, vecs[i].q);
      chk($sformatf("vec%0d_disch", i), disch, vecs[i].d);
      chk_r($sformatf("vec%0d_vout", i), vout, vecs[i].q ? 5.0 : 0.0);
      chk($sformatf("vec%0d_meas_valid", i), meas_valid, vecs[i].mv);
      chk($sformatf("vec%0d_high_cnt", i), high_cnt, vecs[i].hc);
      chk($sformatf("vec%0d_low_cnt", i), low_cnt, vecs[i].lc);
      chk($sformatf("vec%0d_cycles", i), cycles, vecs[i].cy);
    end

    // ---------------- saturation: 20 CHARGE clocks ----------------
    do_reset();
    step(1, 0.0);
    step(1, 3.34);
    step(1, 1.0);
    $display("sat: start-up cycle closed, mv=%0b", meas_valid);
    chk("sat_startup_mv", meas_valid, 0);
    for (int i = 0; i < 19; i++) step(1, 2.0);
    step(1, 3.34);
    step(1, 1.0);
    $display("sat: h16=%0d h4=%0d l16=%0d l4=%0d mv=%0b/%0b",
             high_cnt, high_cnt4, low_cnt, low_cnt4, meas_valid, meas_valid4);
    chk("sat_mv16", meas_valid, 1);
    chk("sat_mv4", meas_valid4, 1);
    chk("sat_high16", high_cnt, 20);
    chk("sat_high4", high_cnt4, 15);
    chk("sat_low16", low_cnt, 1);
    chk("sat_low4", low_cnt4, 1);
    chk("sat_cycles4", cycles4, 1);

    // ---------------- enable drop in DISCH ----------------
    step(1, 3.34);
    chk("endrop_pre_disch", disch, 1);
    step(1, 2.0);
    step(0, 2.0);
    $display("endrop: out_q=%0b disch=%0b vout=%f h=%0d l=%0d cyc=%0d mv=%0b",
             out_q, disch, vout, high_cnt, low_cnt, cycles, meas_valid);
    chk("endrop_out_q", out_q, 0);
    chk("endrop_disch", disch, 0);
    chk_r("endrop_vout", vout, 0.0);
    chk("endrop_mv", meas_valid, 0);
    chk("endrop_high_hold", high_cnt, 20);
    chk("endrop_low_hold", low_cnt, 1);
    chk("endrop_cycles_hold", cycles, 1);
    // Re-enable: start-up cycle must again be skipped.
    step(1, 0.0);
    step(1, 3.34);
    step(1, 1.0);
    $display("reenable: mv=%0b cyc=%0d", meas_valid, cycles);
    chk("reenable_startup_mv", meas_valid, 0);
    chk("reenable_cycles", cycles, 1);

    // ---------------- async reset between edges ----------------
    step(1, 2.0);
    chk("arst_pre_out_q", out_q, 1);
    #2;
    rst = 1'b1;
    #1;
    $display("arst: vout=%f out_q=%0b h=%0d cyc=%0d", vout, out_q, high_cnt, cycles);
    chk_r("arst_vout_immediate", vout, 0.0);
    chk("arst_out_q_immediate", out_q, 0);
    chk("arst_high_cnt", high_cnt, 0);
    chk("arst_cycles", cycles, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- closed loop with RC network ----------------
    // One clock represents 1 ns; tau = R*C = 100 ns. Exact exponential update per clock.
    tau_ratio = $exp(-1.0e-9 / (100.0 * 1.0e-9));
    vc = 0.0;
    vmin = 10.0;
    vmax = -10.0;
    started = 1'b0;
    nmeas = 0;
    prev_h = -1;
    prev_l = -1;
    en = 1'b1;
    vcap = vc;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      vc = vout + (vc - vout) * tau_ratio;
      vcap = vc;
      if (started) begin
        if (vc < vmin) vmin = vc;
        if (vc > vmax) vmax = vc;
      end
      if (!out_q) started = 1'b1;
      if (meas_valid) begin
        nmeas++;
        $display("loop meas %0d: high=%0d low=%0d cycles=%0d", nmeas, high_cnt, low_cnt, cycles);
        if (prev_h >= 0) begin
          dh = int'(high_cnt) - prev_h;
          dl = int'(low_cnt) - prev_l;
          chk_ok($sformatf("loop_high_delta%0d", nmeas), (dh <= 1) && (dh >= -1), real'(dh), "|d|<=1");
          chk_ok($sformatf("loop_low_delta%0d", nmeas), (dl <= 1) && (dl >= -1), real'(dl), "|d|<=1");
        end
        prev_h = int'(high_cnt);
        prev_l = int'(low_cnt);
      end
    end
    // A crossing is only seen on the sample after it happens, so the cap can pass a
    // threshold by at most one clock's slew (~0.017 V here).
    chk_ok("loop_vmin", vmin >= 1.64, vmin, ">=1.64");
    chk_ok("loop_vmax", vmax <= 3.36, vmax, "<=3.36");
    chk_ok("loop_nmeas", nmeas >= 5, real'(nmeas), ">=5");
    // tau*ln2 is about 69 clocks per phase.
    chk_ok("loop_high_range", (prev_h >= 62) && (prev_h <= 78), real'(prev_h), "62..78");
    chk_ok("loop_low_range", (prev_l >= 62) && (prev_l <= 78), real'(prev_l), "62..78");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
